onehot_decode_seq: RTL and testbench



---
 rtl/onehot_pkg.sv | 9 +
 rtl/onehot_decode_seq_hold_counter.sv | 17 +
 rtl/onehot_decode_seq.sv | 50 +++++
 tb/tb_onehot_decode_seq.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/onehot_pkg.sv
// onehot_pkg: shared widths, state encoding and index-to-one-hot helper
package onehot_pkg;
  localparam int CODE_W = 4;
  localparam int OUT_W = 16;
  typedef enum logic {IDLE = 1'b0, DRIVE = 1'b1} state_t;
  function automatic logic [OUT_W-1:0] onehot_of(input logic [CODE_W-1:0] code);
    return OUT_W'(1) << code;
  endfunction
endpackage

// File: rtl/onehot_decode_seq_hold_counter.sv
// hold_counter: 8-bit load/increment counter flagging HOLD_CYCLES-1
module hold_counter #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       inc,
  output logic [7:0] cnt,
  output logic       term
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= '0;
    else if (inc) cnt <= cnt + 8'd1;
  assign term = cnt == 8'(HOLD_CYCLES - 1);
endmodule

// File: rtl/onehot_decode_seq.sv
// onehot_decode_seq: handshaked index to timed one-hot driver; DEC_STICKY_EN adds sticky_seen
module onehot_decode_seq
  import onehot_pkg::*;
#(
  parameter int CODE_W = onehot_pkg::CODE_W,
  parameter int OUT_W = onehot_pkg::OUT_W,
  parameter int HOLD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CODE_W-1:0] code_in,
  input  logic              code_valid,
  output logic              code_ready,
  output logic [OUT_W-1:0]  d_out,
  output logic              busy,
  output logic              done,
  input  logic              sticky_clr,
  output logic [OUT_W-1:0]  sticky_seen
);
  state_t state;
  logic [CODE_W-1:0] code_q;
  logic [7:0] cnt;
  logic term, accept;
  // counter parks at HOLD_CYCLES-1 once a pattern ends, so term stays high in IDLE
  hold_counter #(.HOLD_CYCLES(HOLD_CYCLES)) u_cnt (
    .clk(clk), .rst_n(rst_n), .load(accept), .inc(busy & ~term), .cnt(cnt), .term(term)
  );
  assign code_ready = rst_n & (state == IDLE | term);
  assign accept = code_valid & code_ready;
  assign busy = state == DRIVE;
  assign done = busy & term;
  assign d_out = busy ? onehot_of(code_q) : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      code_q <= '0;
    end else if (accept) begin
      state <= DRIVE;
      code_q <= code_in;
    end else if (term) state <= IDLE;
`ifdef DEC_STICKY_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sticky_seen <= '0;
    else sticky_seen <= sticky_clr ? '0 : sticky_seen | d_out;
`else
  logic unused_sticky_clr;
  assign unused_sticky_clr = sticky_clr;
  assign sticky_seen = '0;
`endif
endmodule

// File: tb/tb_onehot_decode_seq.sv
// tb_onehot_decode_seq: random and directed checks of HOLD_CYCLES=4 and =1 instances against a countdown model
module tb_onehot_decode_seq;
  logic clk = 0, rst_n;
  logic [3:0] code [2];
  logic valid [2], clr [2], ready [2], busy [2], done [2];
  logic [15:0] d [2], st [2];
  int n_cmp = 0, n_bad = 0;
  bit started = 0;
  int rem [2];
  logic [3:0] mc [2];
  logic [15:0] ms [2];
  always #5 clk = ~clk;
  onehot_decode_seq #(.HOLD_CYCLES(4)) u_a (
    .clk(clk), .rst_n(rst_n), .code_in(code[0]), .code_valid(valid[0]), .code_ready(ready[0]),
    .d_out(d[0]), .busy(busy[0]), .done(done[0]), .sticky_clr(clr[0]), .sticky_seen(st[0]));
  onehot_decode_seq #(.HOLD_CYCLES(1)) u_b (
    .clk(clk), .rst_n(rst_n), .code_in(code[1]), .code_valid(valid[1]), .code_ready(ready[1]),
    .d_out(d[1]), .busy(busy[1]), .done(done[1]), .sticky_clr(clr[1]), .sticky_seen(st[1]));
  function automatic int hold(input int k);
    return k == 0 ? 4 : 1;
  endfunction
  function automatic logic exp_rdy(input int k);
    return rst_n && rem[k] <= 1;
  endfunction
  function automatic logic [15:0] exp_d(input int k);
    return rem[k] > 0 ? 16'h1 << mc[k] : 16'h0;
  endfunction
  function automatic int enc(input logic [15:0] v);
    int r = -1;
    for (int i = 0; i < 16; i++) if (v[i]) r = i;
    return r;
  endfunction
  always @(posedge clk or negedge rst_n)
    if (!rst_n) for (int k = 0; k < 2; k++) begin
      rem[k] <= 0;
      mc[k] <= 0;
      ms[k] <= 0;
    end else for (int k = 0; k < 2; k++) begin
`ifdef DEC_STICKY_EN
      ms[k] <= clr[k] ? 16'h0 : ms[k] | exp_d(k);
`endif
      if (valid[k] && exp_rdy(k)) begin
        mc[k] <= code[k];
        rem[k] <= hold(k);
      end else if (rem[k] > 0) rem[k] <= rem[k] - 1;
    end
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
    end
  endtask
  always @(negedge clk) if (started) for (int k = 0; k < 2; k++) begin
    chk($sformatf("d_out%0d", k), d[k], exp_d(k));
    chk($sformatf("busy%0d", k), busy[k], rem[k] > 0);
    chk($sformatf("done%0d", k), done[k], rem[k] == 1);
    chk($sformatf("ready%0d", k), ready[k], exp_rdy(k));
    chk($sformatf("sticky%0d", k), st[k], ms[k]);
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_rdy();
    int n = 0;
    while (!ready[0] && n < 20) begin
      step();
      n++;
    end
    chk("ready_wait", ready[0], 1);
  endtask
  task automatic send(input logic [3:0] c);
    wait_rdy();
    valid[0] = 1;
    code[0] = c;
    step();
    valid[0] = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    for (int k = 0; k < 2; k++) begin
      code[k] = 0;
      valid[k] = 0;
      clr[k] = 0;
    end
    rst_n = 1;
    #1 rst_n = 0;
    #1 chk("rst_ready", ready[0], 0);
    chk("rst_dout", d[0], 0);
    step();
    step();
    rst_n = 1;
    started = 1;
    #1 chk("rel_ready", ready[0], 1);
    send(4'd5);
    for (int i = 0; i < 4; i++) begin
      chk("c5_dout", d[0], 16'h0020);
      chk("c5_done", done[0], i == 3);
      step();
    end
    chk("c5_idle_dout", d[0], 0);
    chk("c5_idle_busy", busy[0], 0);
    for (int c = 0; c < 16; c++) begin
      send(4'(c));
      for (int i = 0; i < 4; i++) begin
        chk("sweep_enc", enc(d[0]), c);
        step();
      end
    end
    wait_rdy();
    valid[0] = 1;
    code[0] = 3;
    step();
    code[0] = 12;
    for (int i = 0; i < 4; i++) begin
      chk("b2b_d3", d[0], 16'h0008);
      chk("b2b_r3", ready[0], i == 3);
      step();
    end
    valid[0] = 0;
    for (int i = 0; i < 4; i++) begin
      chk("b2b_d12", d[0], 16'h1000);
      chk("b2b_r12", ready[0], i == 3);
      step();
    end
    chk("b2b_end", d[0], 0);
    valid[1] = 1;
    code[1] = 0;
    step();
    chk("h1_d0", d[1], 16'h0001);
    chk("h1_done0", done[1], 1);
    code[1] = 15;
    step();
    chk("h1_d15", d[1], 16'h8000);
    chk("h1_done15", done[1], 1);
    chk("h1_ready", ready[1], 1);
    code[1] = 7;
    step();
    valid[1] = 0;
    chk("h1_d7", d[1], 16'h0080);
    chk("h1_done7", done[1], 1);
    step();
    chk("h1_idle", d[1], 0);
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 2; k++) begin
        valid[k] = 1'($urandom_range(0, 1));
        code[k] = 4'($urandom_range(0, 15));
        clr[k] = $urandom_range(0, 7) == 0;
      end
      step();
    end
    for (int k = 0; k < 2; k++) begin
      valid[k] = 0;
      clr[k] = 0;
    end
    repeat (6) step();
    send(4'd9);
    step();
    #2 rst_n = 0;
    #1 chk("arst_dout", d[0], 0);
    chk("arst_busy", busy[0], 0);
    chk("arst_ready", ready[0], 0);
    #10 rst_n = 1;
    #1 chk("arst_rel_ready", ready[0], 1);
    chk("arst_rel_busy", busy[0], 0);
    step();
`ifdef DEC_STICKY_EN
    send(4'd1);
    repeat (4) step();
    send(4'd14);
    repeat (4) step();
    chk("sticky_4002", st[0], 16'h4002);
    clr[0] = 1;
    step();
    clr[0] = 0;
    chk("sticky_clr", st[0], 0);
`else
    send(4'd1);
    repeat (4) step();
    chk("sticky_off", st[0], 0);
`endif
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
